// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two CPU-side request ports and the shared data-memory port.
// The arbiter takes the master view; the cache front end and memory model take the slave view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 40
);
   logic              enable;
   logic              req0;
   logic              req1;
   logic              rw0;
   logic              rw1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              done0;
   logic              done1;
   logic              err;
   logic [DATA_W-1:0] rdata;
   logic              mem_req;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  enable, req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
      input  mem_ready, mem_rdata,
      output gnt0, gnt1, done0, done1, err, rdata,
      output mem_req, mem_rw, mem_addr, mem_wdata
   );

   modport slave (
      output enable, req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
      output mem_ready, mem_rdata,
      input  gnt0, gnt1, done0, done1, err, rdata,
      input  mem_req, mem_rw, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two cache CPU-side ports,
// with a BUSY-cycle timeout that completes a hung access with an error flag.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 40,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_port_arbiter_if.master   bus
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } stateType;

   stateType          stateReg,    stateNext;
   logic              prioReg,     prioNext;
   logic              ownerReg,    ownerNext;
   logic [CNT_W-1:0]  cntReg,      cntNext;
   logic [1:0]        gntReg,      gntNext;
   logic [1:0]        doneReg,     doneNext;
   logic              errReg,      errNext;
   logic [DATA_W-1:0] rdataReg,    rdataNext;
   logic              memReqReg,   memReqNext;
   logic              memRwReg,    memRwNext;
   logic [ADDR_W-1:0] memAddrReg,  memAddrNext;
   logic [DATA_W-1:0] memWdataReg, memWdataNext;

   logic [1:0]        reqVec;
   logic [1:0]        rwVec;
   logic [ADDR_W-1:0] addrVec  [2];
   logic [DATA_W-1:0] wdataVec [2];
   logic              pick;

   assign reqVec      = {bus.req1, bus.req0};
   assign rwVec       = {bus.rw1, bus.rw0};
   assign addrVec[0]  = bus.addr0;
   assign addrVec[1]  = bus.addr1;
   assign wdataVec[0] = bus.wdata0;
   assign wdataVec[1] = bus.wdata1;

   // prioReg names the port that wins a tie; a lone requester always wins.
   assign pick = (reqVec == 2'b11) ? prioReg : reqVec[1];

   always_comb begin
      stateNext    = stateReg;
      prioNext     = prioReg;
      ownerNext    = ownerReg;
      cntNext      = cntReg;
      gntNext      = gntReg;
      doneNext     = doneReg;
      errNext      = errReg;
      rdataNext    = rdataReg;
      memReqNext   = memReqReg;
      memRwNext    = memRwReg;
      memAddrNext  = memAddrReg;
      memWdataNext = memWdataReg;

      case (stateReg)
         IDLE: begin
            if (bus.enable && (|reqVec)) begin
               ownerNext     = pick;
               memRwNext     = rwVec[pick];
               memAddrNext   = addrVec[pick];
               memWdataNext  = wdataVec[pick];
               memReqNext    = 1'b1;
               gntNext       = 2'b00;
               gntNext[pick] = 1'b1;
               cntNext       = '0;
               stateNext     = BUSY;
            end
         end

         BUSY: begin
            if (cntReg != CNT_MAX) begin
               cntNext = cntReg + CNT_W'(1);
            end
            // A ready arriving on the final allowed cycle still counts as success.
            if (bus.mem_ready) begin
               if (memRwReg) begin
                  rdataNext = bus.mem_rdata;
               end
               memReqNext         = 1'b0;
               doneNext[ownerReg] = 1'b1;
               errNext            = 1'b0;
               stateNext          = DONE;
            end else if ((TIMEOUT != 0) && (cntReg == CNT_LAST)) begin
               rdataNext          = '0;
               memReqNext         = 1'b0;
               doneNext[ownerReg] = 1'b1;
               errNext            = 1'b1;
               stateNext          = DONE;
            end
         end

         DONE: begin
            doneNext  = 2'b00;
            errNext   = 1'b0;
            gntNext   = 2'b00;
            prioNext  = ~ownerReg;
            stateNext = IDLE;
         end

         default: begin
            stateNext  = IDLE;
            gntNext    = 2'b00;
            doneNext   = 2'b00;
            errNext    = 1'b0;
            memReqNext = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateReg    <= IDLE;
         prioReg     <= 1'b0;
         ownerReg    <= 1'b0;
         cntReg      <= '0;
         gntReg      <= 2'b00;
         doneReg     <= 2'b00;
         errReg      <= 1'b0;
         rdataReg    <= '0;
         memReqReg   <= 1'b0;
         memRwReg    <= 1'b0;
         memAddrReg  <= '0;
         memWdataReg <= '0;
      end else begin
         stateReg    <= stateNext;
         prioReg     <= prioNext;
         ownerReg    <= ownerNext;
         cntReg      <= cntNext;
         gntReg      <= gntNext;
         doneReg     <= doneNext;
         errReg      <= errNext;
         rdataReg    <= rdataNext;
         memReqReg   <= memReqNext;
         memRwReg    <= memRwNext;
         memAddrReg  <= memAddrNext;
         memWdataReg <= memWdataNext;
      end
   end

   assign bus.gnt0      = gntReg[0];
   assign bus.gnt1      = gntReg[1];
   assign bus.done0     = doneReg[0];
   assign bus.done1     = doneReg[1];
   assign bus.err       = errReg;
   assign bus.rdata     = rdataReg;
   assign bus.mem_req   = memReqReg;
   assign bus.mem_rw    = memRwReg;
   assign bus.mem_addr  = memAddrReg;
   assign bus.mem_wdata = memWdataReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants and completions,
// a negedge monitor pops and compares them whenever the DUT raises mem_req or a done pulse.
module tb_mem_port_arbiter;

   typedef struct {
      int          port;
      logic        rw;
      logic [31:0] addr;
      logic [39:0] wdata;
      int          cyc;
   } GntExp;

   typedef struct {
      int          port;
      logic        err;
      logic [39:0] rdata;
      int          cyc;
   } DoneExp;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;
   int   doneSeen;
   bit   phaseA;
   bit   sawGnt1;

   GntExp  gntQ[$];
   DoneExp doneQ[$];

   // memory model controls
   bit          respEn;
   bit          toggleReady;
   bit          useAddrData;
   int          memLat;
   logic [39:0] respData;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(40)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(40), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d required=<20000", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expGnt(input int port, input logic rw, input logic [31:0] addr,
                         input logic [39:0] wdata, input int c);
      GntExp g;
      g.port = port; g.rw = rw; g.addr = addr; g.wdata = wdata; g.cyc = c;
      gntQ.push_back(g);
   endtask

   task automatic expDone(input int port, input logic e, input logic [39:0] rdata, input int c);
      DoneExp d;
      d.port = port; d.err = e; d.rdata = rdata; d.cyc = c;
      doneQ.push_back(d);
   endtask

   // Wait for the given port's done pulse and drop its request in that same cycle.
   task automatic waitDoneDrop(input int port, input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (port == 0 && bus.done0) begin
            got = 1'b1;
            bus.req0 = 1'b0;
         end else if (port == 1 && bus.done1) begin
            got = 1'b1;
            bus.req1 = 1'b0;
         end
      end
      check($sformatf("done_wait_p%0d", port), 128'(got), 128'(1));
   endtask

   // Memory responder: ready memLat cycles after mem_req is first seen.
   initial begin
      int waitCnt;
      bit phase;
      waitCnt = 0;
      phase = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ready = 1'b0;
         if (toggleReady) begin
            phase = ~phase;
            bus.mem_ready = phase;
            bus.mem_rdata = 40'hFF_FFFF_FFFF;
            waitCnt = 0;
         end else if (bus.mem_req && respEn) begin
            if (waitCnt == memLat) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = useAddrData ? {8'hC0, bus.mem_addr} : respData;
               waitCnt = 0;
            end else begin
               waitCnt = waitCnt + 1;
            end
         end else begin
            waitCnt = 0;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      bit prevMemReq;
      GntExp  g;
      DoneExp d;
      prevMemReq = 1'b0;
      forever begin
         @(negedge clk);
         if (phaseA && bus.gnt1) sawGnt1 = 1'b1;
         if (bus.mem_req && !prevMemReq) begin
            if (gntQ.size() == 0) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL gnt_unexpected: actual=mem_req addr %0h required=no grant (cyc %0d)",
                        bus.mem_addr, cyc);
            end else begin
               g = gntQ.pop_front();
               check("gnt_port", 128'({bus.gnt1, bus.gnt0}), 128'((g.port == 0) ? 2'b01 : 2'b10));
               check("gnt_rw", 128'(bus.mem_rw), 128'(g.rw));
               check("gnt_addr", 128'(bus.mem_addr), 128'(g.addr));
               check("gnt_wdata", 128'(bus.mem_wdata), 128'(g.wdata));
               check("gnt_cycle", 128'(cyc), 128'(g.cyc));
               $display("grant  port=%0d rw=%0d addr=%08h wdata=%010h cyc=%0d",
                        g.port, bus.mem_rw, bus.mem_addr, bus.mem_wdata, cyc);
            end
         end
         prevMemReq = bus.mem_req;
         if (bus.done0 || bus.done1) begin
            doneSeen = doneSeen + 1;
            if (doneQ.size() == 0) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL done_unexpected: actual=done %0b%0b required=no done (cyc %0d)",
                        bus.done1, bus.done0, cyc);
            end else begin
               d = doneQ.pop_front();
               check("done_port", 128'({bus.done1, bus.done0}), 128'((d.port == 0) ? 2'b01 : 2'b10));
               check("done_gnt", 128'({bus.gnt1, bus.gnt0}), 128'((d.port == 0) ? 2'b01 : 2'b10));
               check("done_err", 128'(bus.err), 128'(d.err));
               check("done_rdata", 128'(bus.rdata), 128'(d.rdata));
               check("done_cycle", 128'(cyc), 128'(d.cyc));
               $display("done   port=%0d err=%0d rdata=%010h cyc=%0d", d.port, bus.err, bus.rdata, cyc);
            end
         end
      end
   end

   initial begin
      int t0;
      int base;
      int run;
      bit got;
      int nDone[2];
      bit rr[2];

      checks = 0; errors = 0; doneSeen = 0; phaseA = 1'b1; sawGnt1 = 1'b0;
      respEn = 1'b1; toggleReady = 1'b1; useAddrData = 1'b0; memLat = 2;
      respData = 40'h12_3456_789A;
      rst = 1'b0;
      bus.enable = 1'b1;
      bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 32'h0000_1000; bus.wdata0 = 40'h11_1111_1111;
      bus.req1 = 1'b0; bus.rw1 = 1'b1; bus.addr1 = 32'h0; bus.wdata1 = 40'h22_2222_2222;

      // Reset held with a pending request and a toggling mem_ready.
      for (int i = 0; i < 4; i++) begin
         tick();
         check("reset_outputs",
               128'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.rdata,
                     bus.mem_req, bus.mem_rw, bus.mem_addr, bus.mem_wdata}), 128'(0));
      end
      toggleReady = 1'b0;

      // Single read on port 0, first grant after reset.
      tick();
      rst = 1'b1;
      t0 = cyc;
      expGnt(0, 1'b1, 32'h0000_1000, 40'h11_1111_1111, t0 + 1);
      expDone(0, 1'b0, 40'h12_3456_789A, t0 + 4);
      waitDoneDrop(0, 20);
      tick();
      phaseA = 1'b0;
      check("single_read_no_gnt1", 128'(sawGnt1), 128'(0));

      // mem_ready while idle must be ignored.
      base = doneSeen;
      toggleReady = 1'b1;
      repeat (4) tick();
      toggleReady = 1'b0;
      repeat (2) tick();
      check("stray_ready_no_done", 128'(doneSeen), 128'(base));

      // Write on port 1: rdata keeps the earlier read value.
      memLat = 0; respData = 40'hDE_ADBE_EF00;
      bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 32'h0000_2000; bus.wdata1 = 40'hAA_5555_AAAA;
      t0 = cyc;
      expGnt(1, 1'b0, 32'h0000_2000, 40'hAA_5555_AAAA, t0 + 1);
      expDone(1, 1'b0, 40'h12_3456_789A, t0 + 2);
      waitDoneDrop(1, 20);
      tick();

      // enable low: a request sits ungranted.
      bus.enable = 1'b0;
      bus.req0 = 1'b1; bus.addr0 = 32'h0000_3000;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("enable_gate", 128'({bus.gnt0, bus.mem_req}), 128'(0));
      end
      bus.req0 = 1'b0;
      tick();
      bus.enable = 1'b1;
      tick();

      // Contention: both held, expect 0,1,0,1 with done every 4 cycles.
      memLat = 1; useAddrData = 1'b1;
      bus.rw0 = 1'b1; bus.addr0 = 32'h0000_0100; bus.wdata0 = 40'h11_1111_1111;
      bus.rw1 = 1'b1; bus.addr1 = 32'h0000_0200; bus.wdata1 = 40'h22_2222_2222;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      t0 = cyc;
      expGnt(0, 1'b1, 32'h0000_0100, 40'h11_1111_1111, t0 + 1);
      expGnt(1, 1'b1, 32'h0000_0200, 40'h22_2222_2222, t0 + 5);
      expGnt(0, 1'b1, 32'h0000_0100, 40'h11_1111_1111, t0 + 9);
      expGnt(1, 1'b1, 32'h0000_0200, 40'h22_2222_2222, t0 + 13);
      expDone(0, 1'b0, 40'hC0_0000_0100, t0 + 3);
      expDone(1, 1'b0, 40'hC0_0000_0200, t0 + 7);
      expDone(0, 1'b0, 40'hC0_0000_0100, t0 + 11);
      expDone(1, 1'b0, 40'hC0_0000_0200, t0 + 15);
      nDone[0] = 0; nDone[1] = 0; rr[0] = 1'b0; rr[1] = 1'b0;
      for (int i = 0; i < 60 && !(nDone[0] == 2 && nDone[1] == 2); i++) begin
         tick();
         if (rr[0]) begin bus.req0 = 1'b1; rr[0] = 1'b0; end
         if (rr[1]) begin bus.req1 = 1'b1; rr[1] = 1'b0; end
         if (bus.done0) begin
            bus.req0 = 1'b0; nDone[0]++;
            if (nDone[0] < 2) rr[0] = 1'b1;
         end
         if (bus.done1) begin
            bus.req1 = 1'b0; nDone[1]++;
            if (nDone[1] < 2) rr[1] = 1'b1;
         end
      end
      check("rr_done_count", 128'(nDone[0] + nDone[1]), 128'(4));
      tick();

      // Timeout: no mem_ready, mem_req lasts exactly TIMEOUT cycles.
      respEn = 1'b0;
      bus.req0 = 1'b1; bus.addr0 = 32'h0000_0400;
      t0 = cyc;
      expGnt(0, 1'b1, 32'h0000_0400, 40'h11_1111_1111, t0 + 1);
      expDone(0, 1'b1, 40'h0, t0 + 5);
      run = 0; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (bus.mem_req) run++;
         if (bus.done0) begin got = 1'b1; bus.req0 = 1'b0; end
      end
      check("timeout_done_wait", 128'(got), 128'(1));
      check("timeout_req_cycles", 128'(run), 128'(4));
      tick();

      // Port 1 served normally after a timeout.
      respEn = 1'b1; memLat = 0;
      bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 32'h0000_0500;
      t0 = cyc;
      expGnt(1, 1'b1, 32'h0000_0500, 40'h22_2222_2222, t0 + 1);
      expDone(1, 1'b0, 40'hC0_0000_0500, t0 + 2);
      waitDoneDrop(1, 20);
      tick();

      // mem_ready on the last allowed BUSY cycle wins over the timeout.
      memLat = 3;
      bus.req0 = 1'b1; bus.addr0 = 32'h0000_0600;
      t0 = cyc;
      expGnt(0, 1'b1, 32'h0000_0600, 40'h11_1111_1111, t0 + 1);
      expDone(0, 1'b0, 40'hC0_0000_0600, t0 + 5);
      waitDoneDrop(0, 20);
      tick();

      // Reset during BUSY drops mem_req at once and produces no done.
      respEn = 1'b0;
      bus.req0 = 1'b1; bus.addr0 = 32'h0000_0700;
      t0 = cyc;
      expGnt(0, 1'b1, 32'h0000_0700, 40'h11_1111_1111, t0 + 1);
      tick();
      tick();
      check("busy_before_reset", 128'(bus.mem_req), 128'(1));
      base = doneSeen;
      rst = 1'b0;
      #1;
      check("reset_in_busy", 128'({bus.mem_req, bus.gnt0}), 128'(0));
      bus.req0 = 1'b0;
      tick();
      rst = 1'b1;
      repeat (3) tick();
      check("reset_no_done", 128'(doneSeen), 128'(base));

      // After reset the tie goes to port 0 again.
      respEn = 1'b1; memLat = 0;
      bus.addr0 = 32'h0000_0800; bus.addr1 = 32'h0000_0900;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      t0 = cyc;
      expGnt(0, 1'b1, 32'h0000_0800, 40'h11_1111_1111, t0 + 1);
      expGnt(1, 1'b1, 32'h0000_0900, 40'h22_2222_2222, t0 + 4);
      expDone(0, 1'b0, 40'hC0_0000_0800, t0 + 2);
      expDone(1, 1'b0, 40'hC0_0000_0900, t0 + 5);
      waitDoneDrop(0, 20);
      waitDoneDrop(1, 20);
      repeat (3) tick();

      check("gnt_queue_empty", 128'(gntQ.size()), 128'(0));
      check("done_queue_empty", 128'(doneQ.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
